uart_rx_oversampled: RTL and testbench

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

---
 rtl/uart_rx_oversampled.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, single-entry output buffer
// with acknowledge handshake, frame-error pulse and sticky overrun flag.
module uart_rx_oversampled #(
  parameter int unsigned DATA_BW        = 8,
  parameter int unsigned BAUD_COUNT_x16 = 651,
  parameter int unsigned BAUD_BIT_x16   = 10,
  parameter int unsigned OVER_SAMPL     = 16,
  parameter int unsigned OVER_SAMPL_BIT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               In_Data_Serial,
  input  logic               rx_ack,
  output logic [DATA_BW-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               overrun,
  output logic               rx_busy
);

  localparam int unsigned BitCntW = $clog2(DATA_BW + 1);

  localparam logic [BAUD_BIT_x16-1:0]   TickLast = BAUD_BIT_x16'(BAUD_COUNT_x16 - 1);
  localparam logic [OVER_SAMPL_BIT-1:0] OsHalf   = OVER_SAMPL_BIT'(OVER_SAMPL / 2 - 1);
  localparam logic [OVER_SAMPL_BIT-1:0] OsLast   = OVER_SAMPL_BIT'(OVER_SAMPL - 1);
  localparam logic [BitCntW-1:0]        BitLast  = BitCntW'(DATA_BW - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                    state_q, state_d;
  logic                      sync1_q, sync2_q, line_prev_q;
  logic [BAUD_BIT_x16-1:0]   tick_cnt_q, tick_cnt_d;
  logic [OVER_SAMPL_BIT-1:0] os_cnt_q, os_cnt_d;
  logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BW-1:0]        shift_q, shift_d;
  logic [DATA_BW-1:0]        rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;

  logic line;
  logic tick;
  logic start_edge;
  logic good_frame;

  assign line = sync2_q;
  assign tick = (tick_cnt_q == TickLast);
  // A falling edge (not merely a low level) arms a frame, so a line held low after a
  // bad stop bit cannot retrigger until it has returned high.
  assign start_edge = (state_q == StIdle) && line_prev_q && !line;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    good_frame  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          os_cnt_d   = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (os_cnt_q == OsHalf) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = line ? StIdle : StData;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (os_cnt_q == OsLast) begin
            os_cnt_d = '0;
            shift_d  = DATA_BW'({line, shift_q} >> 1);
            if (bit_cnt_q == BitLast) begin
              state_d = StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (os_cnt_q == OsLast) begin
            os_cnt_d    = '0;
            state_d     = StIdle;
            good_frame  = line;
            frame_err_d = !line;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output buffer: an ack in the completion cycle frees the slot for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (good_frame) begin
      if (rx_valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= In_Data_Serial;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: frame-level model checked every cycle, plus directed
// literal checks on each scenario. Uses a fast baud divider to keep runs short.
module tb_uart_rx_oversampled;

  localparam int DataBw     = 8;
  localparam int Baud       = 4;
  localparam int Os         = 16;
  localparam int BitClks    = Baud * Os;
  localparam int FrameTicks = Os / 2 + Os * DataBw + Os;
  // Two synchronizer flops plus the registered start detection.
  localparam int Pipe       = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              line = 1'b1;
  logic              ack = 1'b0;
  logic [DataBw-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              overrun;
  logic              rx_busy;

  uart_rx_oversampled #(
    .DATA_BW       (DataBw),
    .BAUD_COUNT_x16(Baud),
    .BAUD_BIT_x16  (3),
    .OVER_SAMPL    (Os),
    .OVER_SAMPL_BIT(5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .In_Data_Serial(line),
    .rx_ack        (ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model state: the output buffer as the consumer sees it.
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;
  bit         pend_on = 1'b0;
  bit         pend_good = 1'b0;
  int         pend_cyc = 0;
  logic [7:0] pend_data = 8'h00;
  int         fe_seen = 0;
  int         valid_rise = -1;
  bit         prev_valid = 1'b0;
  int         c0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    bit rst_s, ack_s, v0, fe_exp;
    forever begin
      @(posedge clk);
      cyc++;
      rst_s = rst;
      ack_s = ack;
      #1;
      fe_exp = 1'b0;
      if (!rst_s) begin
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        pend_on = 1'b0;
      end else begin
        v0 = m_valid;
        if (ack_s) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
        if (pend_on && cyc == pend_cyc) begin
          pend_on = 1'b0;
          if (!pend_good) fe_exp = 1'b1;
          else if (v0 && !ack_s) m_ovr = 1'b1;
          else begin
            m_data  = pend_data;
            m_valid = 1'b1;
          end
        end
      end
      chk("cyc_rx_valid", rx_valid, m_valid);
      chk("cyc_rx_data", rx_data, m_data);
      chk("cyc_overrun", overrun, m_ovr);
      chk("cyc_frame_err", frame_err, fe_exp);
      if (frame_err === 1'b1) fe_seen++;
      if (rx_valid === 1'b1 && !prev_valid) valid_rise = cyc;
      prev_valid = (rx_valid === 1'b1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Drives one full frame; optionally raises ack exactly on the completion edge.
  task automatic send(input logic [7:0] d, input bit stop, input bit ack_end,
                      output int start_cyc);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    start_cyc = cyc;
    pend_data = d;
    pend_good = stop;
    pend_cyc  = start_cyc + Pipe + FrameTicks * Baud;
    pend_on   = 1'b1;
    for (int i = 0; i < 10 * BitClks; i++) begin
      if (i > 0) @(negedge clk);
      line = bits[i / BitClks];
      ack  = ack_end && (cyc == pend_cyc - 1);
    end
    ack = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (4) @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_rx_busy", rx_busy, 1'b0);
    rst = 1'b1;
    idle(10);

    // Good frame 0xA5 and its latency.
    send(8'hA5, 1'b1, 1'b0, c0);
    idle(40);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1'b1);
    lat = valid_rise - c0 - Pipe;
    chk("a5_latency_window",
        (valid_rise >= 0 && lat >= (FrameTicks - 1) * Baud && lat <= (FrameTicks + 1) * Baud), 1);
    ack_pulse();
    idle(2);
    chk("a5_ack_valid", rx_valid, 1'b0);
    ack_pulse();
    idle(2);
    chk("idle_ack_data", rx_data, 8'hA5);
    chk("idle_ack_overrun", overrun, 1'b0);

    // Four-tick low glitch.
    @(negedge clk);
    line = 1'b0;
    idle(10);
    chk("glitch_busy_mid", rx_busy, 1'b1);
    idle(4 * Baud - 10);
    line = 1'b1;
    idle(2 * BitClks);
    chk("glitch_busy_after", rx_busy, 1'b0);
    chk("glitch_no_valid", rx_valid, 1'b0);
    chk("glitch_no_fe", fe_seen, 0);

    // Bad stop bit; line stays low afterwards and must not re-arm.
    send(8'h3C, 1'b0, 1'b0, c0);
    idle(BitClks);
    chk("fe_no_rearm_busy", rx_busy, 1'b0);
    line = 1'b1;
    idle(BitClks);
    chk("fe_pulse_count", fe_seen, 1);
    chk("fe_data_kept", rx_data, 8'hA5);
    chk("fe_valid_kept", rx_valid, 1'b0);

    // Overrun: 0x11 then 0x22 without ack.
    send(8'h11, 1'b1, 1'b0, c0);
    send(8'h22, 1'b1, 1'b0, c0);
    idle(20);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", overrun, 1'b1);
    ack_pulse();
    idle(2);
    chk("ovr_ack_valid", rx_valid, 1'b0);
    chk("ovr_ack_flag", overrun, 1'b0);

    // Reset during bit 4 of an 0xFF frame, then 0x5A.
    @(negedge clk);
    line = 1'b0;
    idle(BitClks);
    line = 1'b1;
    idle(4 * BitClks + 20);
    chk("abort_busy_mid", rx_busy, 1'b1);
    rst = 1'b0;
    idle(4);
    rst = 1'b1;
    idle(1);
    chk("abort_busy_after", rx_busy, 1'b0);
    chk("abort_data", rx_data, 8'h00);
    idle(6 * BitClks);
    chk("abort_no_valid", rx_valid, 1'b0);
    chk("abort_no_fe", fe_seen, 1);
    send(8'h5A, 1'b1, 1'b0, c0);
    idle(20);
    chk("post_abort_data", rx_data, 8'h5A);
    chk("post_abort_valid", rx_valid, 1'b1);

    // Ack coincident with completion of 0x77 while 0x5A still pending.
    send(8'h77, 1'b1, 1'b1, c0);
    idle(5);
    chk("coinc_data", rx_data, 8'h77);
    chk("coinc_valid", rx_valid, 1'b1);
    chk("coinc_overrun", overrun, 1'b0);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
